// File: rtl/ultrasonido_sched.sv
// Round-robin scheduler sharing one ultrasonic measurement core among N_SENS sensors.
// Optional macro ULTRA_SCHED_AVG_EN: good results are averaged with the previous stored value.
module ultrasonido_sched #(
  parameter int N_SENS      = 4,
  parameter int SEL_W       = 2,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int GAP_CYC     = 500000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                run_i,
  input  logic [N_SENS-1:0]   mask_i,
  output logic                meas_en_o,
  input  logic                meas_done_i,
  input  logic [7:0]          meas_d_i,
  output logic [SEL_W-1:0]    sel_o,
  output logic [8*N_SENS-1:0] dist_o,
  output logic [N_SENS-1:0]   valid_o,
  output logic [N_SENS-1:0]   err_o,
  output logic                frame_done_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_STORE,
    S_GAP
  } state_t;

  localparam int CNT_MAX_A = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYC) ? CNT_MAX_A : GAP_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   first_idx, next_idx;
  logic [N_SENS-1:0]  mask_sh;
  logic               next_found, next_wrap;
  logic               tmo_q, tmo_d;
  logic               done_q, done_q2, done_evt;
  logic               meas_en_q, meas_en_d;
  logic               frame_done_q, frame_done_d;
  logic               gap_last;

  // Only a fresh rising edge of the synchronised done counts; a level held from before is ignored.
  assign done_evt = done_q & ~done_q2;
  assign gap_last = (state_q == S_GAP) && (cnt_q == GAP_LAST);

  always_comb begin
    first_idx  = '0;
    next_idx   = sel_q;
    next_found = 1'b0;
    mask_sh    = '0;
    for (int k = N_SENS - 1; k >= 0; k--) begin
      mask_sh = mask_i >> k;
      if (mask_sh[0]) first_idx = SEL_W'(k);
    end
    // Descending scan leaves the nearest set bit above sel, wrapping round to sel itself.
    for (int k = N_SENS; k >= 1; k--) begin
      mask_sh = mask_i >> ((int'(sel_q) + k) % N_SENS);
      if (mask_sh[0]) begin
        next_idx   = SEL_W'((int'(sel_q) + k) % N_SENS);
        next_found = 1'b1;
      end
    end
  end

  assign next_wrap = (next_idx <= sel_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      tmo_q        <= 1'b0;
      done_q       <= 1'b0;
      done_q2      <= 1'b0;
      meas_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      tmo_q        <= tmo_d;
      done_q       <= meas_done_i;
      done_q2      <= done_q;
      meas_en_q    <= meas_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run_i && (mask_i != '0)) begin
          sel_d   = first_idx;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (done_evt) begin
          tmo_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_STORE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_last) begin
          cnt_d = '0;
          if (run_i && next_found) begin
            sel_d   = next_idx;
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    meas_en_d    = (state_d == S_MEASURE);
    frame_done_d = gap_last && next_found && next_wrap;
  end

  assign meas_en_o    = meas_en_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (state_q != S_IDLE);
  assign sel_o        = sel_q;

  for (genvar gi = 0; gi < N_SENS; gi++) begin : g_bank
    logic [7:0] dist_r;
    logic       valid_r;
    logic       err_r;
    logic [7:0] store_val;
    logic       wr_en;

`ifdef ULTRA_SCHED_AVG_EN
    logic [8:0] sum;
    assign sum       = {1'b0, dist_r} + {1'b0, meas_d_i} + 9'd1;
    // After a timeout the slot holds 8'hFF, so the next good result restarts raw.
    assign store_val = (valid_r && !err_r) ? sum[8:1] : meas_d_i;
`else
    assign store_val = meas_d_i;
`endif

    assign wr_en = (state_q == S_STORE) && (sel_q == SEL_W'(gi));

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        dist_r  <= 8'h00;
        valid_r <= 1'b0;
        err_r   <= 1'b0;
      end else if (wr_en) begin
        if (tmo_q) begin
          dist_r <= 8'hFF;
          err_r  <= 1'b1;
        end else begin
          dist_r  <= store_val;
          valid_r <= 1'b1;
          err_r   <= 1'b0;
        end
      end
    end

    assign dist_o[8*gi +: 8] = dist_r;
    assign valid_o[gi]       = valid_r;
    assign err_o[gi]         = err_r;
  end

endmodule

// File: doc/ultrasonido_sched.md
Name: ultrasonido_sched

Overview:
Round-robin scheduler that shares one ultrasonic measurement core (trigger/echo/count/divide chain) among N_SENS sensors. It selects a sensor, which steers the external trigg/ECHO mux, and enables the core. It then waits for the core's done flag (with timeout) and stores the 8-bit distance per sensor, then inserts an inter-measurement gap so echoes from one sensor cannot corrupt the next. Sits between the measurement core and the game/display logic that reads the distance bank.

Parameters:
N_SENS, 4, number of sensors served (2..8)
SEL_W, 2, width of sensor select (>= clog2(N_SENS))
SETTLE_CYC, 16, clk cycles after a select change before meas_en rises
TIMEOUT_CYC, 2000000, max clk cycles in MEASURE before abort
GAP_CYC, 500000, clk cycles idle between measurements

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  level; 1 = keep scanning, 0 = stop after current measurement
mask  in  N_SENS  1 = sensor included in the scan
meas_en  out  1  drives the core's ENABLE
meas_done  in  1  core's DONE (level, may stay high)
meas_d  in  8  core's distance result
sel  out  SEL_W  current sensor index (echo/trigger mux select)
dist  out  8*N_SENS  distance bank, sensor i at [8i+7:8i]
valid  out  N_SENS  sensor i holds at least one good result since reset
err  out  N_SENS  sensor i's last measurement timed out
frame_done  out  1  one-cycle pulse when a full scan of enabled sensors completes
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (async): state IDLE, sel=0, meas_en=0, dist=0, valid=0, err=0, frame_done=0, busy=0, all counters 0.
- meas_done is registered once. The event is a rising edge of the registered value (done_q & ~done_q2). A done that is already high on entry to MEASURE is not an event.
- States:
  - IDLE: if run=1 and mask!=0, sel <= lowest set mask index; go to SETTLE. If mask=0, stay in IDLE.
  - SETTLE: count SETTLE_CYC cycles, then go to MEASURE with meas_en=1 from the first MEASURE cycle.
  - MEASURE: meas_en=1 and the timeout counter increments.
    - On done event: go to STORE.
    - If the counter reaches TIMEOUT_CYC-1 without an event: go to STORE with a timeout flag.
    - Done and timeout in the same cycle: done wins.
  - STORE (1 cycle): meas_en=0.
    - Good result: dist[sel] <= meas_d, valid[sel] <= 1, err[sel] <= 0.
    - Timeout: dist[sel] <= 8'hFF, err[sel] <= 1, valid unchanged.
    - Go to GAP.
  - GAP: count GAP_CYC cycles. Then pick the next set mask bit above sel, wrapping.
    - If wrap occurred (next index <= sel), pulse frame_done for that cycle.
    - If run=0, go to IDLE. Otherwise sel <= next and go to SETTLE.
- Mask is sampled only at sensor selection. Clearing a bit mid-measurement does not abort; that sensor is skipped next time.
- Single enabled sensor: same sensor is re-selected and frame_done pulses after every measurement.
- meas_en is registered, glitch-free, and low in every state except MEASURE.
- Latency, per sensor: SETTLE_CYC + measurement + 1 + GAP_CYC cycles.
- Reset mid-operation returns immediately to the reset values; the bank is cleared.

Optional Feature:
ULTRA_SCHED_AVG_EN
- Defined: on a good result with valid[sel]=1, dist[sel] <= (dist[sel] + meas_d + 1) >> 1, using a 9-bit sum. The first good result, or a result after a timeout, is stored raw. err behaviour is unchanged.
- Undefined: raw store only, and no adder is present.

Test Plan:
1. Run with mask=4'b1111 (SETTLE_CYC=4, GAP_CYC=8 for sim); the core model answers with d = 10, 20, 30, 40 per sensor -> sel steps 0,1,2,3; dist = {40,30,20,10}; valid=4'hF; frame_done pulses once, in the GAP exit after sensor 3.
2. mask=4'b0101, run held -> only sel 0 and 2 visited; sensors 1 and 3 keep dist=0 and valid=0.
3. Core never asserts done for sensor 1 (TIMEOUT_CYC=50) -> meas_en drops after exactly 50 MEASURE cycles; dist[1]=8'hFF; err[1]=1; the scan continues to sensor 2. A later good result clears err[1].
4. meas_done held high entering MEASURE, falls, then rises on cycle 7 -> STORE occurs only after the cycle-7 rise. A done rise on the same cycle as the timeout counter hitting its limit -> good result stored.
5. run deasserted during MEASURE of sensor 2 -> the measurement completes, dist[2] is stored, the GAP completes, then IDLE with busy=0. Async reset mid-SETTLE -> all outputs are zero immediately.
6. With ULTRA_SCHED_AVG_EN, sensor 0 returns 100 then 51 -> dist[0]=100 then 76.
